// File: rtl/rx_gearbox_32to66_if.sv
// rtl/rx_gearbox_32to66_if.sv - line-side input and block-side output bundle of the 32-to-66 receive gearbox
//
// Signals:
//   in_data / in_valid        raw 32-bit line words from the transceiver
//   serdes_rx_bitslip         slip request level from the PHY block-lock logic
//   serdes_rx_data / _hdr     66-bit block split into 64-bit payload and 2-bit sync header
//   out_valid                 one-cycle pulse per emitted block
//   slip_offset               alignment offset modulo 66 (present only with GEARBOX_SLIP_COUNT_EN)
// Modports: master drives the line side and observes blocks; slave is the gearbox.
interface rx_gearbox_32to66_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        serdes_rx_bitslip;
    logic [63:0] serdes_rx_data;
    logic [1:0]  serdes_rx_hdr;
    logic        out_valid;
`ifdef GEARBOX_SLIP_COUNT_EN
    logic [6:0]  slip_offset;

    modport master (
        output in_data, in_valid, serdes_rx_bitslip,
        input  serdes_rx_data, serdes_rx_hdr, out_valid, slip_offset
    );
    modport slave (
        input  in_data, in_valid, serdes_rx_bitslip,
        output serdes_rx_data, serdes_rx_hdr, out_valid, slip_offset
    );
`else
    modport master (
        output in_data, in_valid, serdes_rx_bitslip,
        input  serdes_rx_data, serdes_rx_hdr, out_valid
    );
    modport slave (
        input  in_data, in_valid, serdes_rx_bitslip,
        output serdes_rx_data, serdes_rx_hdr, out_valid
    );
`endif
endinterface

// File: rtl/rx_gearbox_32to66.sv
// rtl/rx_gearbox_32to66.sv - 32-bit line word to 66-bit 10GBASE-R block receive gearbox with bitslip
//
// Ports:
//   rx_clk    receive clock (single domain)
//   rx_rst_n  synchronous active-low reset
//   bus       rx_gearbox_32to66_if.slave: in_data/in_valid/serdes_rx_bitslip in,
//             serdes_rx_data/serdes_rx_hdr/out_valid out
// Optional feature macro: GEARBOX_SLIP_COUNT_EN adds bus.slip_offset, a modulo-66
// count of applied slips.
module rx_gearbox_32to66 #(
    parameter bit BIT_REVERSE = 1'b0,
    parameter int IN_WIDTH    = 32,
    parameter int BUF_WIDTH   = 98
) (
    input logic                rx_clk,
    input logic                rx_rst_n,
    rx_gearbox_32to66_if.slave bus
);

    // acc_q holds unconsumed line bits, bit 0 oldest; cnt_q of them are valid.
    logic [BUF_WIDTH-1:0] acc_q;
    logic [6:0]           cnt_q;
    logic                 slip_pending_q;
    logic                 bitslip_prev_q;
    logic [63:0]          data_q;
    logic [1:0]           hdr_q;
    logic                 valid_q;

    logic [IN_WIDTH-1:0]  word;
    logic [BUF_WIDTH-1:0] merged;
    logic [6:0]           merged_cnt;
    logic                 emit;
    logic                 slip_rise;

    always_comb begin
        word = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            word[i] = BIT_REVERSE ? bus.in_data[IN_WIDTH-1-i] : bus.in_data[i];
        end
    end

    // Append the new word above the valid bits, then drop the oldest bit if a
    // slip is pending. At least 32 bits are present here so the slip never underflows.
    always_comb begin
        merged     = acc_q | (BUF_WIDTH'(word) << cnt_q);
        merged_cnt = cnt_q + 7'(IN_WIDTH);
        if (slip_pending_q) begin
            merged     = merged >> 1;
            merged_cnt = merged_cnt - 7'd1;
        end
        emit = (merged_cnt >= 7'd66);
    end

    assign slip_rise = bus.serdes_rx_bitslip & ~bitslip_prev_q;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            slip_pending_q <= 1'b0;
            bitslip_prev_q <= 1'b0;
            data_q         <= '0;
            hdr_q          <= '0;
            valid_q        <= 1'b0;
        end else begin
            bitslip_prev_q <= bus.serdes_rx_bitslip;
            valid_q        <= 1'b0;
            if (bus.in_valid) begin
                if (emit) begin
                    hdr_q   <= merged[1:0];
                    data_q  <= merged[65:2];
                    valid_q <= 1'b1;
                    acc_q   <= merged >> 66;
                    cnt_q   <= merged_cnt - 7'd66;
                end else begin
                    acc_q <= merged;
                    cnt_q <= merged_cnt;
                end
            end
            // An edge seen while a slip is still pending is dropped, not queued.
            if (bus.in_valid && slip_pending_q) begin
                slip_pending_q <= 1'b0;
            end else if (slip_rise) begin
                slip_pending_q <= 1'b1;
            end
        end
    end

    assign bus.serdes_rx_data = data_q;
    assign bus.serdes_rx_hdr  = hdr_q;
    assign bus.out_valid      = valid_q;

`ifdef GEARBOX_SLIP_COUNT_EN
    logic [6:0] slip_offset_q;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            slip_offset_q <= '0;
        end else if (bus.in_valid && slip_pending_q) begin
            slip_offset_q <= (slip_offset_q == 7'd65) ? 7'd0 : slip_offset_q + 7'd1;
        end
    end

    assign bus.slip_offset = slip_offset_q;
`endif

    // Bits above the fill level must stay clear, otherwise the OR-merge corrupts data.
    buf_upper_clear: assert property (@(posedge rx_clk) disable iff (!rx_rst_n)
        (((acc_q >> cnt_q) == '0) && (cnt_q <= 7'd65)));

endmodule

// File: tb/tb_rx_gearbox_32to66.sv
// tb/tb_rx_gearbox_32to66.sv - self-checking bench for rx_gearbox_32to66 (LSB-first and bit-reversed instances)
module tb_rx_gearbox_32to66;

    localparam logic [65:0] IDLE_BLK = {64'h0707070707070707, 2'b01};

    logic rx_clk = 1'b0;
    logic rx_rst_n = 1'b0;

    rx_gearbox_32to66_if bus0 ();
    rx_gearbox_32to66_if bus1 ();

    always #5 rx_clk = ~rx_clk;

    rx_gearbox_32to66 #(.BIT_REVERSE(1'b0)) dut0 (
        .rx_clk   (rx_clk),
        .rx_rst_n (rx_rst_n),
        .bus      (bus0.slave)
    );

    rx_gearbox_32to66 #(.BIT_REVERSE(1'b1)) dut1 (
        .rx_clk   (rx_clk),
        .rx_rst_n (rx_rst_n),
        .bus      (bus1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Line bits still to be sent, in transmission order.
    bit          line[$];
    // Reference model: the bits received but not yet emitted, oldest first.
    bit          mq[$];
    bit          m_pend;
    bit          m_prev;
    int          m_off;
    logic [65:0] src[$];
    logic [65:0] exp_b[$];
    logic [65:0] got_b0[$];
    logic [65:0] got_b1[$];
    bit          exp_v[$];
    logic [1:0]  got_v[$];

    task automatic push_block(input logic [1:0] h, input logic [63:0] d);
        for (int k = 0; k < 2; k++) line.push_back(h[k]);
        for (int k = 0; k < 64; k++) line.push_back(d[k]);
        src.push_back({d, h});
    endtask

    task automatic step(input bit v, input bit bs);
        logic [31:0] w_lsb;
        logic [31:0] w_msb;
        logic [65:0] blk;
        bit b, e, pend_before, rise;
        w_lsb = $urandom;
        w_msb = $urandom;
        if (v) begin
            for (int i = 0; i < 32; i++) begin
                if (line.size() > 0) b = line.pop_front();
                else b = 1'($urandom);
                w_lsb[i]    = b;
                w_msb[31-i] = b;
                mq.push_back(b);
            end
        end
        rx_rst_n                = 1'b1;
        bus0.in_valid           = v;
        bus1.in_valid           = v;
        bus0.in_data            = w_lsb;
        bus1.in_data            = w_msb;
        bus0.serdes_rx_bitslip  = bs;
        bus1.serdes_rx_bitslip  = bs;
        pend_before = m_pend;
        rise        = bs && !m_prev;
        e           = 1'b0;
        blk         = '0;
        if (v && pend_before) begin
            b      = mq.pop_front();
            m_pend = 1'b0;
            m_off  = (m_off + 1) % 66;
        end
        if (v && mq.size() >= 66) begin
            for (int k = 0; k < 66; k++) blk[k] = mq.pop_front();
            e = 1'b1;
        end
        if (rise && !pend_before) m_pend = 1'b1;
        m_prev = bs;
        @(posedge rx_clk);
        #1;
        exp_v.push_back(e);
        got_v.push_back({bus1.out_valid, bus0.out_valid});
        if (e) exp_b.push_back(blk);
        if (bus0.out_valid) got_b0.push_back({bus0.serdes_rx_data, bus0.serdes_rx_hdr});
        if (bus1.out_valid) got_b1.push_back({bus1.serdes_rx_data, bus1.serdes_rx_hdr});
    endtask

    task automatic do_reset();
        rx_rst_n               = 1'b0;
        bus0.in_valid          = 1'b0;
        bus1.in_valid          = 1'b0;
        bus0.in_data           = $urandom;
        bus1.in_data           = $urandom;
        bus0.serdes_rx_bitslip = 1'b0;
        bus1.serdes_rx_bitslip = 1'b0;
        @(posedge rx_clk);
        #1;
        mq.delete();
        line.delete();
        src.delete();
        exp_b.delete();
        got_b0.delete();
        got_b1.delete();
        exp_v.delete();
        got_v.delete();
        m_pend = 1'b0;
        m_prev = 1'b0;
        m_off  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus0.out_valid, bus0.serdes_rx_hdr, bus0.serdes_rx_data} !== 67'd0)
            $display("FAIL reset_dut0 got %h expected 0", {bus0.out_valid, bus0.serdes_rx_hdr, bus0.serdes_rx_data});
        else n_pass++;
        n_checks++;
        if ({bus1.out_valid, bus1.serdes_rx_hdr, bus1.serdes_rx_data} !== 67'd0)
            $display("FAIL reset_dut1 got %h expected 0", {bus1.out_valid, bus1.serdes_rx_hdr, bus1.serdes_rx_data});
        else n_pass++;
`ifdef GEARBOX_SLIP_COUNT_EN
        n_checks++;
        if (bus0.slip_offset !== 7'd0 || bus1.slip_offset !== 7'd0)
            $display("FAIL reset_offset got %0d/%0d expected 0", bus0.slip_offset, bus1.slip_offset);
        else n_pass++;
`endif
    endtask

    task automatic test_aligned();
        int first;
        do_reset();
        for (int i = 0; i < 16; i++) push_block(2'b01, 64'h0707070707070707);
        for (int c = 0; c < 33; c++) step(1'b1, 1'b0);
        first = -1;
        for (int i = 0; i < got_v.size(); i++) if (got_v[i] != 2'b00 && first < 0) first = i;
        n_checks++;
        if (first != 2) $display("FAIL aligned_first_valid got word %0d expected word 2", first);
        else n_pass++;
        n_checks++;
        if (got_b0.size() != 16 || got_b1.size() != 16)
            $display("FAIL aligned_count got %0d/%0d expected 16", got_b0.size(), got_b1.size());
        else n_pass++;
        for (int i = 0; i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== IDLE_BLK || got_b1[i] !== IDLE_BLK)
                $display("FAIL aligned_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], IDLE_BLK);
            else n_pass++;
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== {exp_v[i], exp_v[i]})
                $display("FAIL aligned_valid cycle %0d got %b expected %b", i, got_v[i], {exp_v[i], exp_v[i]});
            else n_pass++;
        end
    endtask

    task automatic test_misalign();
        int nb;
        do_reset();
        for (int i = 0; i < 5; i++) line.push_back(1'($urandom));
        for (int i = 0; i < 40; i++) push_block(2'b01, 64'h0707070707070707);
        for (int c = 0; c < 83; c++) step(1'b1, (c % 9 == 0) && (c < 45));
        n_checks++;
        if (got_b0.size() != exp_b.size() || got_b1.size() != exp_b.size() || exp_b.size() != 40)
            $display("FAIL misalign_count got %0d/%0d expected %0d", got_b0.size(), got_b1.size(), exp_b.size());
        else n_pass++;
        for (int i = 0; i < exp_b.size() && i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== exp_b[i] || got_b1[i] !== exp_b[i])
                $display("FAIL misalign_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], exp_b[i]);
            else n_pass++;
        end
        nb = (got_b0.size() < got_b1.size()) ? got_b0.size() : got_b1.size();
        for (int i = (nb > 20) ? nb - 20 : 0; i < nb; i++) begin
            n_checks++;
            if (got_b0[i] !== IDLE_BLK || got_b1[i] !== IDLE_BLK)
                $display("FAIL misalign_locked %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], IDLE_BLK);
            else n_pass++;
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== {exp_v[i], exp_v[i]})
                $display("FAIL misalign_valid cycle %0d got %b expected %b", i, got_v[i], {exp_v[i], exp_v[i]});
            else n_pass++;
        end
`ifdef GEARBOX_SLIP_COUNT_EN
        n_checks++;
        if (bus0.slip_offset !== 7'd5 || bus1.slip_offset !== 7'd5)
            $display("FAIL misalign_offset got %0d/%0d expected 5", bus0.slip_offset, bus1.slip_offset);
        else n_pass++;
`endif
    endtask

    task automatic test_wraparound();
        int nb;
        do_reset();
        for (int i = 0; i < 100; i++) push_block(2'b01, {$urandom, $urandom});
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0);
        for (int s = 0; s < 66; s++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        for (int c = 0; c < 60; c++) step(1'b1, 1'b0);
        n_checks++;
        if (got_b0.size() != exp_b.size() || got_b1.size() != exp_b.size())
            $display("FAIL wrap_count got %0d/%0d expected %0d", got_b0.size(), got_b1.size(), exp_b.size());
        else n_pass++;
        for (int i = 0; i < exp_b.size() && i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== exp_b[i] || got_b1[i] !== exp_b[i])
                $display("FAIL wrap_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], exp_b[i]);
            else n_pass++;
        end
        // 66 dropped bits are exactly one block: late output j is source block j+1.
        nb = (got_b0.size() < got_b1.size()) ? got_b0.size() : got_b1.size();
        for (int i = (nb > 20) ? nb - 20 : 0; i < nb && i + 1 < src.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== src[i+1] || got_b1[i] !== src[i+1])
                $display("FAIL wrap_realigned %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], src[i+1]);
            else n_pass++;
        end
`ifdef GEARBOX_SLIP_COUNT_EN
        n_checks++;
        if (bus0.slip_offset !== 7'd0 || bus1.slip_offset !== 7'd0)
            $display("FAIL wrap_offset got %0d/%0d expected 0", bus0.slip_offset, bus1.slip_offset);
        else n_pass++;
`endif
    endtask

    task automatic test_held_duplicate_slip();
        do_reset();
        line.push_back(1'($urandom));
        for (int i = 0; i < 16; i++) push_block(2'b01, 64'h0707070707070707);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 32; c++) step(1'b1, 1'b0);
        n_checks++;
        if (got_b0.size() != 16 || got_b1.size() != 16)
            $display("FAIL held_count got %0d/%0d expected 16", got_b0.size(), got_b1.size());
        else n_pass++;
        for (int i = 0; i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== IDLE_BLK || got_b1[i] !== IDLE_BLK)
                $display("FAIL held_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], IDLE_BLK);
            else n_pass++;
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== {exp_v[i], exp_v[i]})
                $display("FAIL held_valid cycle %0d got %b expected %b", i, got_v[i], {exp_v[i], exp_v[i]});
            else n_pass++;
        end
`ifdef GEARBOX_SLIP_COUNT_EN
        n_checks++;
        if (bus0.slip_offset !== 7'd1 || bus1.slip_offset !== 7'd1)
            $display("FAIL held_offset got %0d/%0d expected 1", bus0.slip_offset, bus1.slip_offset);
        else n_pass++;
`endif
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 20; i++) push_block(2'($urandom), {$urandom, $urandom});
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b0);
        for (int c = 0; c < 37; c++) step(1'b1, 1'b0);
        for (int i = 5; i < 12; i++) begin
            n_checks++;
            if (got_v[i] !== 2'b00) $display("FAIL stall_quiet cycle %0d got %b expected 00", i, got_v[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_b0.size() != 20 || got_b1.size() != 20)
            $display("FAIL stall_count got %0d/%0d expected 20", got_b0.size(), got_b1.size());
        else n_pass++;
        for (int i = 0; i < src.size() && i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== src[i] || got_b1[i] !== src[i])
                $display("FAIL stall_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], src[i]);
            else n_pass++;
        end
        for (int i = 0; i < exp_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== {exp_v[i], exp_v[i]})
                $display("FAIL stall_valid cycle %0d got %b expected %b", i, got_v[i], {exp_v[i], exp_v[i]});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_stream();
        int first;
        do_reset();
        for (int i = 0; i < 4; i++) push_block(2'b10, {$urandom, $urandom});
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        do_reset();
        n_checks++;
        if ({bus0.out_valid, bus0.serdes_rx_hdr, bus0.serdes_rx_data} !== 67'd0 ||
            {bus1.out_valid, bus1.serdes_rx_hdr, bus1.serdes_rx_data} !== 67'd0)
            $display("FAIL midreset_outputs got %h/%h expected 0",
                     {bus0.out_valid, bus0.serdes_rx_hdr, bus0.serdes_rx_data},
                     {bus1.out_valid, bus1.serdes_rx_hdr, bus1.serdes_rx_data});
        else n_pass++;
        for (int i = 0; i < 16; i++) push_block(2'b01, {$urandom, $urandom});
        for (int c = 0; c < 33; c++) step(1'b1, 1'b0);
        first = -1;
        for (int i = 0; i < got_v.size(); i++) if (got_v[i] != 2'b00 && first < 0) first = i;
        n_checks++;
        if (first != 2) $display("FAIL midreset_first_valid got word %0d expected word 2", first);
        else n_pass++;
        n_checks++;
        if (got_b0.size() != 16 || got_b1.size() != 16)
            $display("FAIL midreset_count got %0d/%0d expected 16", got_b0.size(), got_b1.size());
        else n_pass++;
        for (int i = 0; i < src.size() && i < got_b0.size() && i < got_b1.size(); i++) begin
            n_checks++;
            if (got_b0[i] !== src[i] || got_b1[i] !== src[i])
                $display("FAIL midreset_block %0d got %h/%h expected %h", i, got_b0[i], got_b1[i], src[i]);
            else n_pass++;
        end
`ifdef GEARBOX_SLIP_COUNT_EN
        n_checks++;
        if (bus0.slip_offset !== 7'd0 || bus1.slip_offset !== 7'd0)
            $display("FAIL midreset_offset got %0d/%0d expected 0", bus0.slip_offset, bus1.slip_offset);
        else n_pass++;
`endif
    endtask

    initial begin
        bus0.in_valid          = 1'b0;
        bus1.in_valid          = 1'b0;
        bus0.in_data           = '0;
        bus1.in_data           = '0;
        bus0.serdes_rx_bitslip = 1'b0;
        bus1.serdes_rx_bitslip = 1'b0;
        test_reset();
        test_aligned();
        test_misalign();
        test_wraparound();
        test_held_duplicate_slip();
        test_stall();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
